// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for an eight-digit common-anode
// seven-segment display. The eight character words are snapshotted once per
// frame. Each digit slot opens with a guard interval that has all anodes off,
// which prevents ghosting between digits.
// Optional feature: define SEG7_BLINK_EN to add the blink port and the frame
// counter that blanks the anodes on alternate blink half-periods.
module seg7_scan_driver #(
    parameter int unsigned DIV          = 100000,
    parameter int unsigned GUARD        = 2000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] d1,
    input  logic [6:0] d2,
    input  logic [6:0] d3,
    input  logic [6:0] d4,
    input  logic [6:0] d5,
    input  logic [6:0] d6,
    input  logic [6:0] d7,
    input  logic [6:0] d8,
`ifdef SEG7_BLINK_EN
    input  logic       blink,
`endif
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] slot_cnt;
    logic [2:0]    idx;
    logic [6:0]    snap [8];
    logic [6:0]    din  [8];
    logic          frame_start;
    logic          slot_last;
    logic [6:0]    cur_word;
    logic [7:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;

    assign din[0] = d1;
    assign din[1] = d2;
    assign din[2] = d3;
    assign din[3] = d4;
    assign din[4] = d5;
    assign din[5] = d6;
    assign din[6] = d7;
    assign din[7] = d8;

    assign frame_start = (slot_cnt == '0) && (idx == 3'd0);
    assign slot_last   = (slot_cnt == CW'(DIV - 1));

    // At the frame start the snapshot is being loaded this very edge, so digit 0
    // is decoded straight from its input. That puts d1 on seg one cycle after release.
    assign cur_word = frame_start ? d1 : snap[idx];

    // Character code to cathode pattern {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] decode(input logic [4:0] code);
        logic [6:0] pat;
        case (code)
            5'h00:   pat = 7'b1000000;
            5'h01:   pat = 7'b1111001;
            5'h02:   pat = 7'b0100100;
            5'h03:   pat = 7'b0110000;
            5'h04:   pat = 7'b0011001;
            5'h05:   pat = 7'b1100001;
            5'h06:   pat = 7'b0010010;
            5'h07:   pat = 7'b0000110;
            5'h08:   pat = 7'b0000111;
            5'h09:   pat = 7'b1000001;
            5'h0A:   pat = 7'b0001100;
            5'h0B:   pat = 7'b0000011;
            5'h0C:   pat = 7'b1000110;
            5'h0D:   pat = 7'b1000111;
            5'h0E:   pat = 7'b0010001;
            5'h0F:   pat = 7'b1000010;
            5'h11:   pat = 7'b0111111;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

`ifdef SEG7_BLINK_EN
    localparam int unsigned FW = (BLINK_FRAMES > 0) ? $clog2(2 * BLINK_FRAMES) : 1;

    logic [FW-1:0] frame_cnt;

    // Frame counter for blinking. It is held at 0 while blink is low, so a blink
    // request always starts with the visible half.
    always_ff @(posedge clock) begin
        if (!reset || !blink) begin
            frame_cnt <= '0;
        end else if (slot_last && (idx == 3'd7)) begin
            frame_cnt <= (frame_cnt == FW'(2 * BLINK_FRAMES - 1)) ? '0 : frame_cnt + FW'(1);
        end
    end
`else
    logic unused_blink_frames;
    assign unused_blink_frames = (BLINK_FRAMES != 0);
`endif

    // Slot and digit counters. idx advances each time slot_cnt wraps.
    always_ff @(posedge clock) begin
        if (!reset) begin
            slot_cnt <= '0;
            idx      <= 3'd0;
        end else if (slot_last) begin
            slot_cnt <= '0;
            idx      <= idx + 3'd1;
        end else begin
            slot_cnt <= slot_cnt + CW'(1);
        end
    end

    // Load the snapshot once per frame so that no frame shows mixed input states.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) snap[i] <= 7'd0;
        end else if (frame_start) begin
            for (int i = 0; i < 8; i++) snap[i] <= din[i];
        end
    end

    // Next-state values for the output registers: guard/drive phase and digit decode.
    always_comb begin
        an_next  = 8'hFF;
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        if (slot_cnt >= CW'(GUARD)) begin
            an_next = ~(8'b1 << idx);
        end
`ifdef SEG7_BLINK_EN
        if (blink && (frame_cnt >= FW'(BLINK_FRAMES))) begin
            an_next = 8'hFF;
        end
`endif
        if (cur_word[6]) begin
            seg_next = decode(cur_word[5:1]);
            dp_next  = cur_word[0];
        end
    end

    // Registered outputs. Reset puts the display dark.
    always_ff @(posedge clock) begin
        if (!reset) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule
